// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: sizes, IR field positions, opcodes, states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_sequencer_pkg;

   localparam int NREGS = 16;
   localparam int OPW   = 5;
   localparam int REGW  = 4;

   // IR field positions: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15]
   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_LSB = 15;

   // Opcodes executed by this sequencer
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      CLS_BINARY,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_ILLEGAL
   } op_class_t;

   // Groups an opcode by the execute sequence it needs.
   function automatic op_class_t classify(input logic [OPW-1:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       cls = CLS_BINARY;
         OP_MUL, OP_DIV:                        cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                        cls = CLS_UNARY;
         default:                               cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/control_sequencer_reg_sel_decode.sv
// Register field to one-hot select: 4-bit register number plus enable -> 16-bit one-hot vector.
// Latency: combinational.
// Backpressure: none.
module control_sequencer_reg_sel_decode
   import control_sequencer_pkg::*;
(
   input  logic [REGW-1:0]  sel_i,
   input  logic             en_i,
   output logic [NREGS-1:0] onehot_o
);

   // Expand the selected register number to a single set bit, or all zero when disabled.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control FSM: fetch T0-T2, decode ir in T3, execute register-register ALU ops.
// Latency: 6 cycles binary/unary, 7 cycles mul/div, plus one cycle per T1 memory wait.
// Backpressure: holds T1 (same strobes) until mem_ready; run only consulted in IDLE and final state.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic             PCout,
   output logic             incPC,
   output logic             MARin,
   output logic             Zin,
   output logic             PCin,
   output logic             read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             ZLowOut,
   output logic             ZHighOut,
   output logic             HIin,
   output logic             LOin,
   output logic [NREGS-1:0] rin,
   output logic [NREGS-1:0] rout,
   output logic [OPW-1:0]   opcode,
   output logic             instr_done,
   output logic             halted
);

   state_t          state_q, state_d;
   op_class_t       op_cls;
   logic [OPW-1:0]  op_f;
   logic [REGW-1:0] ra_f, rb_f, rc_f, rout_sel;
   logic            rin_en, rout_en;
   logic            ir_unused;

   assign op_f   = ir[IR_OP_LSB +: OPW];
   assign ra_f   = ir[IR_RA_LSB +: REGW];
   assign rb_f   = ir[IR_RB_LSB +: REGW];
   assign rc_f   = ir[IR_RC_LSB +: REGW];
   assign op_cls = classify(op_f);
   // Low IR bits carry immediates/constants that register-register ops never use.
   assign ir_unused = ^ir[IR_RC_LSB-1:0];

   // State register; clear wins over everything, so an aborted instruction never reaches its write.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and Moore strobes; register selects come from the live ir during execute.
   // An illegal opcode raises halted already in T3 so the stop is visible the cycle after T2.
   always_comb begin
      state_d    = state_q;
      PCout      = 1'b0;
      incPC      = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      ZLowOut    = 1'b0;
      ZHighOut   = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      opcode     = '0;
      instr_done = 1'b0;
      halted     = 1'b0;
      rin_en     = 1'b0;
      rout_en    = 1'b0;
      rout_sel   = rb_f;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_T0;
         end
         ST_T0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            incPC   = 1'b1;
            Zin     = 1'b1;
            opcode  = OP_ADD;
            state_d = ST_T1;
         end
         ST_T1: begin
            ZLowOut = 1'b1;
            PCin    = 1'b1;
            read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_d = ST_T2;
         end
         ST_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = ST_T3;
         end
         ST_T3: begin
            state_d = ST_T4;
            case (op_cls)
               CLS_BINARY: begin
                  rout_en  = 1'b1;
                  rout_sel = rb_f;
                  Yin      = 1'b1;
               end
               CLS_MULDIV: begin
                  rout_en  = 1'b1;
                  rout_sel = ra_f;
                  Yin      = 1'b1;
               end
               CLS_UNARY: begin
               end
               default: begin
                  halted  = 1'b1;
                  state_d = ST_HALT;
               end
            endcase
         end
         ST_T4: begin
            rout_en  = 1'b1;
            rout_sel = (op_cls == CLS_BINARY) ? rc_f : rb_f;
            opcode   = op_f;
            Zin      = 1'b1;
            state_d  = ST_T5;
         end
         ST_T5: begin
            ZLowOut = 1'b1;
            if (op_cls == CLS_MULDIV) begin
               LOin    = 1'b1;
               state_d = ST_T6;
            end else begin
               rin_en     = 1'b1;
               instr_done = 1'b1;
               state_d    = run ? ST_T0 : ST_IDLE;
            end
         end
         ST_T6: begin
            ZHighOut   = 1'b1;
            HIin       = 1'b1;
            instr_done = 1'b1;
            state_d    = run ? ST_T0 : ST_IDLE;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   control_sequencer_reg_sel_decode u_rin_dec (
      .sel_i    (ra_f),
      .en_i     (rin_en),
      .onehot_o (rin)
   );

   control_sequencer_reg_sel_decode u_rout_dec (
      .sel_i    (rout_sel),
      .en_i     (rout_en),
      .onehot_o (rout)
   );

endmodule
